fib_sweep_seq: RTL and testbench

- Initiator/sequencer for the Fibonacci generator's start/ready/done handshake.
- Sweeps a two-digit BCD index range lo..hi. For each index it issues one request, captures the 4-digit BCD result and holds it for a display interval.
- It is the hardware counterpart of the bench-side driver. It sits between the board switch/button logic and fib_ctl, and feeds the 7-segment display path.

---
 rtl/fib_seq_pkg.sv | 39 +++
 rtl/fib_seq_bcd_idx.sv | 43 ++++
 rtl/fib_sweep_seq.sv | 166 ++++++++++++++++
 tb/tb_fib_sweep_seq.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_seq_pkg.sv
// Shared types and BCD helpers for the Fibonacci sweep sequencer.
// The index is a two-digit BCD value.
package fib_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_START,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t d1;
    bcd_digit_t d0;
  } bcd2_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  function automatic logic bcd2_is_valid(bcd2_t v);
    return (v.d1 <= BCD_MAX_DIGIT) &&
           (v.d0 <= BCD_MAX_DIGIT);
  endfunction

  function automatic bcd2_t bcd2_inc(bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.d0 == BCD_MAX_DIGIT) begin
      r.d0 = '0;
      r.d1 = v.d1 + 4'd1;
    end else begin
      r.d0 = v.d0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fib_seq_bcd_idx.sv
// Loadable two-digit BCD index with increment and a compare
// against the latched last index.
module fib_seq_bcd_idx
  import fib_seq_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  inc_i,
  input  bcd2_t lo_i,
  input  bcd2_t hi_i,
  output bcd2_t idx_o,
  output logic  eq_hi_o
);

  bcd2_t idx_q, idx_d;
  bcd2_t hi_q, hi_d;

  always_comb begin
    idx_d = idx_q;
    hi_d  = hi_q;
    if (load_i) begin
      idx_d = lo_i;
      hi_d  = hi_i;
    end else if (inc_i) begin
      idx_d = bcd2_inc(idx_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      hi_q  <= '0;
    end else begin
      idx_q <= idx_d;
      hi_q  <= hi_d;
    end
  end

  assign idx_o   = idx_q;
  assign eq_hi_o = (idx_q == hi_q);

endmodule

// File: rtl/fib_sweep_seq.sv
// Sweep sequencer: walks a BCD index range, requests each Fibonacci
// value from the responder and holds the result for display.
module fib_sweep_seq
  import fib_seq_pkg::*;
#(
  parameter int HOLD_CYC    = 50_000_000,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_go,
  input  logic       i_abort,
  input  logic [3:0] i_lo_bcd1,
  input  logic [3:0] i_lo_bcd0,
  input  logic [3:0] i_hi_bcd1,
  input  logic [3:0] i_hi_bcd0,
  output logic       o_start,
  output logic [3:0] o_amt_bcd1,
  output logic [3:0] o_amt_bcd0,
  input  logic       i_ready,
  input  logic       i_done,
  input  logic [3:0] i_res_bcd3,
  input  logic [3:0] i_res_bcd2,
  input  logic [3:0] i_res_bcd1,
  input  logic [3:0] i_res_bcd0,
  output logic [3:0] o_res_bcd3,
  output logic [3:0] o_res_bcd2,
  output logic [3:0] o_res_bcd1,
  output logic [3:0] o_res_bcd0,
  output logic [3:0] o_idx_bcd1,
  output logic [3:0] o_idx_bcd0,
  output logic       o_res_valid,
  output logic       o_busy,
  output logic       o_sweep_done,
  output logic       o_cfg_err,
  output logic       o_timeout
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0] res_q;
  bcd2_t ridx_q;
  logic rvld_q, sdone_q, cerr_q, tmo_q;

  bcd2_t lo, hi, idx;
  logic eq_hi, busy, rng_ok;
  logic go_req, go_ok, go_bad;
  logic capture, tmo_evt, hold_end, last_hold;

  assign lo     = '{d1: i_lo_bcd1, d0: i_lo_bcd0};
  assign hi     = '{d1: i_hi_bcd1, d0: i_hi_bcd0};
  assign busy   = (state_q != S_IDLE);
  assign rng_ok = bcd2_is_valid(lo) && bcd2_is_valid(hi) &&
                  (lo <= hi);

  assign go_req  = !busy && i_go && !i_abort;
  assign go_ok   = go_req && rng_ok;
  assign go_bad  = go_req && !rng_ok;
  // Abort beats capture and timeout in the same cycle.
  assign capture = (state_q == S_WAIT_DONE) && i_done && !i_abort;
  assign tmo_evt = (state_q == S_WAIT_DONE) && !i_done &&
                   (tcnt_q == TMO_LAST) && !i_abort;
  assign hold_end  = (hcnt_q == HOLD_LAST);
  assign last_hold = (state_q == S_HOLD) && hold_end && !i_abort;

  fib_seq_bcd_idx u_idx (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .load_i  (go_ok),
    .inc_i   (last_hold && !eq_hi),
    .lo_i    (lo),
    .hi_i    (hi),
    .idx_o   (idx),
    .eq_hi_o (eq_hi)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (busy && i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:      if (go_ok)   state_d = S_WAIT_RDY;
        S_WAIT_RDY:  if (i_ready) state_d = S_START;
        S_START:     state_d = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (capture)      state_d = S_HOLD;
          else if (tmo_evt) state_d = S_IDLE;
        end
        S_HOLD: begin
          if (last_hold)
            state_d = eq_hi ? S_IDLE : S_WAIT_RDY;
        end
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_start    = (state_q == S_START) && !i_abort;
    o_busy     = busy;
    o_amt_bcd1 = '0;
    o_amt_bcd0 = '0;
    if (state_q == S_WAIT_RDY || state_q == S_START ||
        state_q == S_WAIT_DONE) begin
      o_amt_bcd1 = idx.d1;
      o_amt_bcd0 = idx.d0;
    end
  end

  // The timeout count starts in START so it spans o_start to i_done.
  always_comb begin
    tcnt_d = '0;
    hcnt_d = '0;
    if (state_q == S_START || state_q == S_WAIT_DONE)
      tcnt_d = tcnt_q + TW'(1);
    if (state_q == S_HOLD)
      hcnt_d = hcnt_q + HW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      res_q   <= '0;
      ridx_q  <= '0;
      rvld_q  <= 1'b0;
      sdone_q <= 1'b0;
      cerr_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      rvld_q  <= capture;
      sdone_q <= last_hold && eq_hi;
      if (capture) begin
        res_q  <= {i_res_bcd3, i_res_bcd2, i_res_bcd1, i_res_bcd0};
        ridx_q <= idx;
      end
      if (go_bad)       cerr_q <= 1'b1;
      else if (go_ok)   cerr_q <= 1'b0;
      if (tmo_evt)      tmo_q  <= 1'b1;
      else if (go_ok)   tmo_q  <= 1'b0;
    end
  end

  assign {o_res_bcd3, o_res_bcd2, o_res_bcd1, o_res_bcd0} = res_q;
  assign o_idx_bcd1   = ridx_q.d1;
  assign o_idx_bcd0   = ridx_q.d0;
  assign o_res_valid  = rvld_q;
  assign o_sweep_done = sdone_q;
  assign o_cfg_err    = cerr_q;
  assign o_timeout    = tmo_q;

endmodule

// File: tb/tb_fib_sweep_seq.sv
// Bench for fib_sweep_seq with a behavioural Fibonacci responder
// and a scoreboard of expected requests and results.
module tb_fib_sweep_seq;

  localparam int HOLD = 4;
  localparam int TMO  = 64;
  localparam int LAT  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0, abort = 1'b0;
  logic [3:0] lo1 = '0, lo0 = '0, hi1 = '0, hi0 = '0;
  logic o_start, ready, done;
  logic [3:0] amt1, amt0;
  logic [3:0] r3, r2, r1, r0, i1, i0;
  logic rvalid, busy, sdone, cerr, tmo;
  logic [15:0] rsp_res;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  amt_q[$];
  logic [23:0] res_q[$];

  always #5 clk = ~clk;

  fib_sweep_seq #(.HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_abort(abort),
    .i_lo_bcd1(lo1), .i_lo_bcd0(lo0),
    .i_hi_bcd1(hi1), .i_hi_bcd0(hi0),
    .o_start(o_start), .o_amt_bcd1(amt1), .o_amt_bcd0(amt0),
    .i_ready(ready), .i_done(done),
    .i_res_bcd3(rsp_res[15:12]), .i_res_bcd2(rsp_res[11:8]),
    .i_res_bcd1(rsp_res[7:4]), .i_res_bcd0(rsp_res[3:0]),
    .o_res_bcd3(r3), .o_res_bcd2(r2),
    .o_res_bcd1(r1), .o_res_bcd0(r0),
    .o_idx_bcd1(i1), .o_idx_bcd0(i0),
    .o_res_valid(rvalid), .o_busy(busy), .o_sweep_done(sdone),
    .o_cfg_err(cerr), .o_timeout(tmo)
  );

  function automatic logic [15:0] fib_bcd(int n);
    int a, b, t;
    a = 0;
    b = 1;
    for (int k = 0; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return {4'(a / 1000), 4'((a / 100) % 10),
            4'((a / 10) % 10), 4'(a % 10)};
  endfunction

  function automatic int bcd2int(logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Responder: idle-ready, answers LAT cycles after o_start.
  logic rsp_stub = 1'b0;
  logic rsp_busy;
  int rsp_cnt, rsp_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_busy <= 1'b0;
      rsp_cnt  <= 0;
      rsp_n    <= 0;
      done     <= 1'b0;
      rsp_res  <= '0;
    end else begin
      done <= 1'b0;
      if (rsp_busy) begin
        if (rsp_cnt == 1) begin
          done     <= 1'b1;
          rsp_res  <= fib_bcd(rsp_n);
          rsp_busy <= 1'b0;
        end
        rsp_cnt <= rsp_cnt - 1;
      end else if (o_start && !rsp_stub) begin
        rsp_busy <= 1'b1;
        rsp_cnt  <= LAT;
        rsp_n    <= bcd2int({amt1, amt0});
      end
    end
  end

  assign ready = rsp_stub ? 1'b1 : !rsp_busy;

  task automatic set_range(input logic [7:0] l, input logic [7:0] h);
    {lo1, lo0} = l;
    {hi1, hi0} = h;
  endtask

  task automatic push_exp(input int l, input int h);
    amt_q.delete();
    res_q.delete();
    for (int n = l; n <= h; n++) begin
      amt_q.push_back(int2bcd(n));
      res_q.push_back({int2bcd(n), fib_bcd(n)});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, o_start, rvalid, sdone, cerr, tmo} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000",
               {busy, o_start, rvalid, sdone, cerr, tmo});
    else n_pass++;
    n_total++;
    if ({r3, r2, r1, r0, i1, i0, amt1, amt0} !== 32'h0)
      $display("FAIL reset_data: got %h want 0",
               {r3, r2, r1, r0, i1, i0, amt1, amt0});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_sweep(input int l, input int h);
    int starts, last_v, cyc;
    bit fin;
    logic [7:0] e_amt;
    logic [23:0] e_res;
    push_exp(l, h);
    set_range(int2bcd(l), int2bcd(h));
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    starts = 0;
    last_v = -1;
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 3000) begin
      if (o_start) begin
        starts++;
        e_amt = (amt_q.size() > 0) ? amt_q.pop_front() : 8'hFF;
        n_total++;
        if ({amt1, amt0} !== e_amt)
          $display("FAIL amt: got %h want %h", {amt1, amt0}, e_amt);
        else n_pass++;
      end
      if (rvalid) begin
        e_res = (res_q.size() > 0) ? res_q.pop_front() : 24'hFFFFFF;
        n_total++;
        if ({i1, i0, r3, r2, r1, r0} !== e_res)
          $display("FAIL result: got idx/res %h want %h",
                   {i1, i0, r3, r2, r1, r0}, e_res);
        else n_pass++;
        if (last_v >= 0) begin
          n_total++;
          if (cyc - last_v < HOLD)
            $display("FAIL hold_gap: got %0d want >= %0d",
                     cyc - last_v, HOLD);
          else n_pass++;
        end
        last_v = cyc;
      end
      if (sdone) fin = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    n_total++;
    if (!fin) $display("FAIL sweep_done: got none want 1");
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL busy_end: got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (starts != h - l + 1)
      $display("FAIL starts: got %0d want %0d", starts, h - l + 1);
    else n_pass++;
    n_total++;
    if (res_q.size() != 0)
      $display("FAIL results_left: got %0d want 0", res_q.size());
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (sdone !== 1'b0) $display("FAIL done_pulse: got %b want 0", sdone);
    else n_pass++;
  endtask

  task automatic test_single();
    run_sweep(0, 0);
  endtask

  task automatic test_carry_sweep();
    run_sweep(8, 12);
  endtask

  task automatic test_cfg_err();
    logic [7:0] los[2];
    logic [7:0] his[2];
    bit bad;
    los[0] = 8'h15; his[0] = 8'h10;
    los[1] = 8'h0A; his[1] = 8'h20;
    for (int k = 0; k < 2; k++) begin
      set_range(los[k], his[k]);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      bad = 0;
      repeat (10) begin
        if (o_start || busy) bad = 1;
        @(negedge clk);
      end
      n_total++;
      if (bad) $display("FAIL cfg_idle_%0d: got activity want none", k);
      else n_pass++;
      n_total++;
      if (cerr !== 1'b1) $display("FAIL cfg_err_%0d: got %b want 1", k, cerr);
      else n_pass++;
      if (k == 0) begin
        run_sweep(0, 0);
        n_total++;
        if (cerr !== 1'b0) $display("FAIL cfg_clear: got %b want 0", cerr);
        else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    int k, c;
    rsp_stub = 1'b1;
    set_range(8'h03, 8'h03);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    k = 0;
    while (!o_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (!o_start) $display("FAIL tmo_start: got 0 want 1");
    else n_pass++;
    c = 0;
    while (!tmo && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_total++;
    if (c != TMO) $display("FAIL tmo_cycles: got %0d want %0d", c, TMO);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL tmo_idle: got %b want 0", busy);
    else n_pass++;
    rsp_stub = 1'b0;
    @(negedge clk);
    run_sweep(1, 1);
    n_total++;
    if (tmo !== 1'b0) $display("FAIL tmo_clear: got %b want 0", tmo);
    else n_pass++;
  endtask

  task automatic test_abort();
    int starts, c, n_sd, n_rv, n_st, n_dn;
    bit aborted;
    logic [23:0] e_res;
    push_exp(18, 18);
    set_range(8'h18, 8'h20);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    starts = 0;
    c = 0;
    aborted = 0;
    while (!aborted && c < 500) begin
      if (rvalid) begin
        e_res = (res_q.size() > 0) ? res_q.pop_front() : 24'hFFFFFF;
        n_total++;
        if ({i1, i0, r3, r2, r1, r0} !== e_res)
          $display("FAIL abort_first: got %h want %h",
                   {i1, i0, r3, r2, r1, r0}, e_res);
        else n_pass++;
      end
      if (o_start) starts++;
      if (starts == 2) begin
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        aborted = 1;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    n_total++;
    if (!aborted || busy !== 1'b0)
      $display("FAIL abort_idle: got busy %b aborted %0d want 0/1",
               busy, aborted);
    else n_pass++;
    n_sd = 0; n_rv = 0; n_st = 0; n_dn = 0;
    repeat (15) begin
      n_sd += int'(sdone);
      n_rv += int'(rvalid);
      n_st += int'(o_start);
      n_dn += int'(done);
      @(negedge clk);
    end
    n_total++;
    if (n_sd + n_rv + n_st != 0)
      $display("FAIL abort_quiet: got sd %0d rv %0d st %0d want 0",
               n_sd, n_rv, n_st);
    else n_pass++;
    n_total++;
    if ({i1, i0, r3, r2, r1, r0} !== 24'h182584 || n_dn != 1)
      $display("FAIL abort_keep: got %h late_done %0d want 182584/1",
               {i1, i0, r3, r2, r1, r0}, n_dn);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    bit bad;
    push_exp(5, 7);
    set_range(8'h05, 8'h07);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    k = 0;
    while (!rvalid && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if ({i1, i0, r3, r2, r1, r0} !== res_q[0])
      $display("FAIL rst_first: got %h want %h",
               {i1, i0, r3, r2, r1, r0}, res_q[0]);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({busy, o_start, rvalid, sdone, cerr, tmo} !== 6'b0 ||
        {r3, r2, r1, r0, i1, i0, amt1, amt0} !== 32'h0)
      $display("FAIL rst_async: got %b %h want 0",
               {busy, o_start, rvalid, sdone, cerr, tmo},
               {r3, r2, r1, r0, i1, i0, amt1, amt0});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_range(8'h01, 8'h02);
    go = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    go = 1'b0;
    abort = 1'b0;
    bad = 0;
    repeat (10) begin
      if (o_start || busy) bad = 1;
      @(negedge clk);
    end
    n_total++;
    if (bad) $display("FAIL go_abort: got activity want none");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry_sweep();
    test_cfg_err();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
